// File: rtl/ctrl_pipe_chain.sv
// ctrl_pipe_chain: control-bundle pipeline with per-stage stall, flush, bubble insertion and valid bits.
// Optional saturating bubble/flush event counter enabled by CTRL_PIPE_BUBBLE_CNT_EN.
module ctrl_pipe_chain #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 3,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          ctrl_d,
    input  logic                      valid_d,
    input  logic [STAGES-1:0]         stall,
    input  logic [STAGES-1:0]         flush,
    output logic [STAGES*WIDTH-1:0]   ctrl_q,
    output logic [STAGES-1:0]         valid_q,
    output logic [CNT_W-1:0]          bubble_cnt
);
    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] clear;

    genvar i;
    generate
        for (i = 0; i < STAGES; i++) begin : g_stage
            logic [WIDTH-1:0] r_c;
            logic             r_v;
            logic [WIDTH-1:0] src_c;
            logic             src_v;
            logic             up_hold;
            // A downstream stall freezes everything upstream of it
            assign hold[i] = |(stall >> i);
            if (i == 0) begin : g_first
                assign src_c   = valid_d ? ctrl_d : '0;
                assign src_v   = valid_d;
                assign up_hold = 1'b0;
            end else begin : g_rest
                assign src_c   = g_stage[i-1].r_c;
                assign src_v   = g_stage[i-1].r_v;
                assign up_hold = hold[i-1];
            end
            // Flush, or a bubble where a held upstream meets a moving downstream
            assign clear[i] = flush[i] | (up_hold & ~hold[i]);
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_c <= '0;
                    r_v <= 1'b0;
                end else if (clear[i]) begin
                    r_c <= '0;
                    r_v <= 1'b0;
                end else if (!hold[i]) begin
                    r_c <= src_c;
                    r_v <= src_v;
                end
            end
            assign ctrl_q[i*WIDTH +: WIDTH] = r_c;
            assign valid_q[i]               = r_v;
        end
    endgenerate

`ifdef CTRL_PIPE_BUBBLE_CNT_EN
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (|clear && cnt != {CNT_W{1'b1}})
            cnt <= cnt + 1'b1;
    end
    assign bubble_cnt = cnt;
`else
    assign bubble_cnt = '0;
`endif
endmodule
